// File: rtl/rw_mem_target.sv
// rtl/rw_mem_target.sv - register-array memory target with fixed read latency and same-address consecutive-write flag
module rw_mem_target #(
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int DW       = 32,
  parameter int RD_DELAY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          write,
  input  logic          wr_valid,
  input  logic          read,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rd_served,
  output logic          wr_err
);

  // Reject unsupported read latencies at elaboration time.
  generate
    if (RD_DELAY < 1 || RD_DELAY > 4) begin : g_bad_rd_delay
      $error("rw_mem_target: RD_DELAY must be within 1..4");
    end
  endgenerate

  logic [DW-1:0]       mem_q [DEPTH];

  // Read pipeline: stage 0 captures the array word, the last stage drives the outputs.
  // A data stage only reloads when a valid entry moves into it, so the last stage
  // keeps the most recently served word while rd_served is low.
  logic [RD_DELAY-1:0] vld_q, vld_d;
  logic [DW-1:0]       data_q [RD_DELAY];
  logic [DW-1:0]       data_d [RD_DELAY];

  // Last accepted write, used to spot two adjacent writes to one address.
  logic                lw_vld_q, lw_vld_d;
  logic [AW-1:0]       lw_addr_q, lw_addr_d;
  logic                wr_err_q, wr_err_d;

  logic                wr_acc;

  assign wr_acc = write && wr_valid;

  // Next state for the read pipeline and the write tracker.
  always_comb begin
    vld_d     = '0;
    lw_vld_d  = 1'b0;
    lw_addr_d = lw_addr_q;
    wr_err_d  = 1'b0;
    for (int i = 0; i < RD_DELAY; i++) begin
      data_d[i] = data_q[i];
    end

    vld_d[0] = read;
    if (read) begin
      data_d[0] = mem_q[addr];
    end
    for (int i = 1; i < RD_DELAY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end

    if (wr_acc) begin
      lw_vld_d  = 1'b1;
      lw_addr_d = addr;
      wr_err_d  = lw_vld_q && (addr == lw_addr_q);
    end
  end

  // Storage array: cleared by reset, written on every accepted write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_acc) begin
      mem_q[addr] <= wdata;
    end
  end

  // Pipeline and tracker registers; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q     <= '0;
      lw_vld_q  <= 1'b0;
      lw_addr_q <= '0;
      wr_err_q  <= 1'b0;
      for (int i = 0; i < RD_DELAY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      vld_q     <= vld_d;
      lw_vld_q  <= lw_vld_d;
      lw_addr_q <= lw_addr_d;
      wr_err_q  <= wr_err_d;
      for (int i = 0; i < RD_DELAY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign rd_served = vld_q[RD_DELAY-1];
  assign rdata     = data_q[RD_DELAY-1];
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_rw_mem_target.sv
// tb/tb_rw_mem_target.sv - directed self-checking bench for rw_mem_target
module tb_rw_mem_target;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic        wr_valid;
  logic        read;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata2, rdata4;
  logic        rd2, rd4;
  logic        err2, err4;

  int checks = 0;
  int errors = 0;
  int pulses;

  rw_mem_target #(.DEPTH(16), .DW(32), .RD_DELAY(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .write(write), .wr_valid(wr_valid), .read(read),
    .addr(addr), .wdata(wdata), .rdata(rdata2), .rd_served(rd2), .wr_err(err2)
  );

  rw_mem_target #(.DEPTH(16), .DW(32), .RD_DELAY(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .write(write), .wr_valid(wr_valid), .read(read),
    .addr(addr), .wdata(wdata), .rdata(rdata4), .rd_served(rd4), .wr_err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge pass, return 1 time unit after it.
  task automatic cyc(input logic w, input logic wv, input logic r,
                     input logic [3:0] a, input logic [31:0] d);
    write    = w;
    wr_valid = wv;
    read     = r;
    addr     = a;
    wdata    = d;
    @(posedge clk);
    #1;
    write    = 1'b0;
    wr_valid = 1'b0;
    read     = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; write = 1'b0; wr_valid = 1'b0; read = 1'b0; addr = '0; wdata = '0;
    #1;
    idle();
    idle();
    chk("reset rd_served", {31'd0, rd2}, 32'd0);
    chk("reset rdata", rdata2, 32'd0);
    chk("reset wr_err", {31'd0, err2}, 32'd0);
    chk("reset d4 rd_served", {31'd0, rd4}, 32'd0);
    rst_n = 1'b1;

    // Read 0..15 back to back after reset: every word reads 0, served two edges later.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 4'(i), 32'd0);
      if (i == 0) chk("first read not yet served", {31'd0, rd2}, 32'd0);
      else begin
        chk("sweep rd_served", {31'd0, rd2}, 32'd1);
        chk("sweep rdata", rdata2, 32'd0);
      end
      if (rd2) pulses++;
    end
    idle();
    chk("sweep last rd_served", {31'd0, rd2}, 32'd1);
    if (rd2) pulses++;
    idle();
    chk("sweep idle rd_served", {31'd0, rd2}, 32'd0);
    chk("sweep pulse count", 32'(pulses), 32'd16);
    idle(); idle();

    // Write then read on the next edge returns the new data.
    cyc(1'b1, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF);
    cyc(1'b0, 1'b0, 1'b1, 4'd3, 32'd0);
    chk("raw latency not early", {31'd0, rd2}, 32'd0);
    idle();
    chk("raw rd_served", {31'd0, rd2}, 32'd1);
    chk("raw rdata", rdata2, 32'hDEADBEEF);
    idle();
    chk("rdata holds after serve", rdata2, 32'hDEADBEEF);

    // Read-before-write and in-flight writes do not disturb captured data.
    cyc(1'b1, 1'b1, 1'b0, 4'd5, 32'h11);
    idle();
    cyc(1'b1, 1'b1, 1'b1, 4'd5, 32'h22);
    cyc(1'b1, 1'b1, 1'b0, 4'd5, 32'h33);
    chk("rbw rd_served", {31'd0, rd2}, 32'd1);
    chk("rbw old data", rdata2, 32'h11);
    chk("rbw back-to-back wr_err", {31'd0, err2}, 32'd1);
    idle();
    chk("wr_err single pulse", {31'd0, err2}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd5, 32'd0);
    idle();
    chk("later read newest", rdata2, 32'h33);

    // Consecutive writes to 7 flag wr_err once; the second write lands.
    cyc(1'b1, 1'b1, 1'b0, 4'd7, 32'h70);
    chk("first write no err", {31'd0, err2}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 4'd7, 32'h71);
    chk("second write err", {31'd0, err2}, 32'd1);
    idle();
    chk("err clears", {31'd0, err2}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd7, 32'd0);
    idle();
    chk("mem7 second data", rdata2, 32'h71);

    // An unqualified write in between breaks adjacency and writes nothing.
    cyc(1'b1, 1'b1, 1'b0, 4'd7, 32'h72);
    cyc(1'b1, 1'b0, 1'b0, 4'd7, 32'h99);
    chk("unqualified no err", {31'd0, err2}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 4'd7, 32'h73);
    chk("gap write no err", {31'd0, err2}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd8, 32'h99);
    cyc(1'b0, 1'b0, 1'b1, 4'd8, 32'd0);
    idle();
    chk("unqualified write ignored", rdata2, 32'd0);
    idle();

    // Four reads in a row through the 4-deep instance.
    cyc(1'b1, 1'b1, 1'b0, 4'd0, 32'hA0);
    cyc(1'b1, 1'b1, 1'b0, 4'd1, 32'hA1);
    cyc(1'b1, 1'b1, 1'b0, 4'd2, 32'hA2);
    cyc(1'b1, 1'b1, 1'b0, 4'd3, 32'hA3);
    chk("distinct addr no err", {31'd0, err4}, 32'd0);
    idle();
    cyc(1'b0, 1'b0, 1'b1, 4'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd1, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd2, 32'd0);
    chk("d4 not early", {31'd0, rd4}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd3, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("d4 stream rd_served", {31'd0, rd4}, 32'd1);
      chk("d4 stream rdata", rdata4, 32'hA0 + 32'(i));
      idle();
    end
    chk("d4 stream ends", {31'd0, rd4}, 32'd0);

    // Reset while reads are in flight drops them and clears memory.
    cyc(1'b0, 1'b0, 1'b1, 4'd3, 32'd0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 4'd3, 32'h55);
    chk("reset drops rd_served", {31'd0, rd2}, 32'd0);
    chk("reset rdata zero", rdata2, 32'd0);
    chk("reset d4 rdata zero", rdata4, 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      idle();
      if (rd2 || rd4) pulses++;
    end
    chk("no pulse after reset", 32'(pulses), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd3, 32'd0);
    idle();
    chk("post reset rd_served", {31'd0, rd2}, 32'd1);
    chk("memory cleared", rdata2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
